fwd_hazard_unit: RTL
====================

# fwd_hazard_unit

Parametrised forwarding and load-use hazard unit for the segmented core. It sits beside the RR (register read) and EX stages. It selects EX operand bypass sources from any of FWD_STAGES downstream producer stages and provides a WB-to-RR write-through bypass. A small state machine stalls RR and inserts an EX bubble for LOAD_LAT cycles on a load-use dependency. A saturating counter records total stall cycles for performance monitoring.

## Interface
- REG_AW, 5: register address width; register 0 is hard-wired zero.
- NUM_SRC, 2: source operands per instruction.
- FWD_STAGES, 2: producer stages after EX; stage 1 = MEM (youngest), stage FWD_STAGES = WB (oldest). Range 1..7.
- LOAD_LAT, 1: load-use stall length in cycles. Range 1..4.
- CNT_W, 16: stall counter width.
- SELW (derived) = clog2(FWD_STAGES+1).

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- src_ex_addr  in  NUM_SRC*REG_AW  EX-stage source addresses; operand i is at bits [i*REG_AW +: REG_AW].
- src_ex_used  in  NUM_SRC  EX operand i is actually read.
- src_rr_addr  in  NUM_SRC*REG_AW  RR-stage source addresses.
- src_rr_used  in  NUM_SRC  RR operand i is actually read.
- dst_addr  in  FWD_STAGES*REG_AW  destination of the instruction in producer stage k (slot k-1).
- dst_we  in  FWD_STAGES  producer stage k writes its destination.
- ex_rd  in  REG_AW  destination of the instruction in EX.
- ex_we  in  1  EX instruction writes a register.
- ex_is_load  in  1  EX instruction is a load.
- flush  in  1  branch/exception flush of RR and EX.
- cnt_clr  in  1  clear the stall counter.
- fwd_sel  out  NUM_SRC*SELW  per EX operand: 0 = register file, k = producer stage k.
- rr_bypass  out  NUM_SRC  per RR operand: take the WB write data instead of the register file.
- stall  out  1  hold PC and the RR pipeline register.
- bubble_ex  out  1  load a NOP into the EX pipeline register.
- stall_cnt  out  CNT_W  saturating count of stalled cycles.

## Operation
- Forward select (combinational), per EX operand i:
  - If src_ex_used[i] = 0 or the address is 0: fwd_sel = 0.
  - Otherwise fwd_sel = the smallest k with dst_we[k] = 1 and dst_addr[k] = src_ex_addr[i]. The youngest producer wins.
  - If no stage matches: 0.
- RR bypass, per RR operand i: rr_bypass[i] = src_rr_used[i] & (address != 0) & dst_we[FWD_STAGES] & (dst_addr[FWD_STAGES] == src_rr_addr[i]).
- Load-use detect: hit = ex_we & ex_is_load & (ex_rd != 0) & (some i has src_rr_used[i] and src_rr_addr[i] == ex_rd).
- FSM has two states, IDLE and STALL, plus a remaining-cycles counter rem of width clog2(LOAD_LAT+1).
  - IDLE: stall = bubble_ex = hit & ~flush.
    - If hit & ~flush and LOAD_LAT > 1: go to STALL with rem = LOAD_LAT-1.
    - Otherwise stay in IDLE.
  - STALL: stall = bubble_ex = 1 and rem decrements each cycle. When rem = 1, return to IDLE next cycle. Hazard detection is ignored in STALL because the bubble now occupies EX.
  - flush in STALL: outputs deassert in that same cycle and the FSM goes to IDLE.
- stall_cnt: increments on each cycle with stall = 1 and saturates at 2^CNT_W-1.
  - cnt_clr takes priority over increment; the counter reads 0 in the next cycle.

## Timing
- fwd_sel and rr_bypass have zero latency: they are purely combinational from the current inputs.
- stall and bubble_ex:
  - The first stall cycle is the detection cycle (Mealy output).
  - Total stall duration is exactly LOAD_LAT consecutive cycles unless flush cuts it short.
- Reset:
  - While rst = 1: FSM = IDLE, rem = 0, stall_cnt = 0.
  - While rst = 1: stall = 0, bubble_ex = 0, fwd_sel = 0, rr_bypass = 0. rst gates all outputs.
  - rst asserted mid-stall aborts the stall in that cycle.
- Simultaneous events:
  - flush together with hit: no stall.
  - cnt_clr together with a stall cycle: counter becomes 0, not 1.
  - Saturated counter together with a stall: stays at maximum.
- Register 0: never forwarded, never bypassed, never causes a hazard.

## Test plan
1. FWD_STAGES=2, src_ex_addr[0]=5, used. Stage1 writes 5 and stage2 writes 5 -> fwd_sel[0]=1. Drop dst_we[0] -> fwd_sel[0]=2. Set src_ex_used[0]=0 -> fwd_sel[0]=0.
2. src_ex_addr[1]=0 with dst_addr=0 and we=1 in both stages -> fwd_sel[1]=0. dst_addr[WB]=7 with we, src_rr_addr[0]=7 -> rr_bypass=01.
3. LOAD_LAT=1: EX holds a load to r3 and RR reads r3 -> stall=bubble_ex=1 for exactly 1 cycle, stall_cnt 0->1.
4. LOAD_LAT=3: same hazard -> stall high for 3 cycles; stall_cnt=3. Asserting flush in cycle 2 -> stall low from cycle 2 on; stall_cnt=1.
5. Hazard together with flush in the same cycle -> no stall. Hazard with ex_rd=0, or with ex_is_load=0 -> no stall.
6. CNT_W=4: force 20 stall cycles -> stall_cnt holds 15. Assert cnt_clr during a stall -> next cycle 0. Assert rst mid-stall -> stall=0 that cycle and FSM in IDLE after release.

Source files
------------

// File: rtl/fwd_hazard_unit.sv
// Forwarding / load-use hazard unit beside the RR and EX stages.
// Latency: fwd_sel, rr_bypass and the first stall cycle are combinational; a load-use stall lasts LOAD_LAT cycles.
// Backpressure: o_stall holds PC and the RR register, o_bubble_ex injects a NOP into EX; i_flush aborts immediately.
//
// Ports:
//   i_clk, i_rst            clock, synchronous active-high reset (also gates every output)
//   i_src_ex_addr/_used     EX operand addresses / read enables (operand i at [i*REG_AW +: REG_AW])
//   i_src_rr_addr/_used     RR operand addresses / read enables
//   i_dst_addr/_we          producer stage k destination in slot k-1 (slot 0 = MEM, last = WB)
//   i_ex_rd/_we/_is_load    instruction currently in EX
//   i_flush, i_cnt_clr      pipeline flush, stall counter clear
//   o_fwd_sel               per EX operand: 0 = register file, k = producer stage k
//   o_rr_bypass             per RR operand: take WB write data
//   o_stall, o_bubble_ex    load-use stall controls
//   o_stall_cnt             saturating count of stalled cycles
module fwd_hazard_unit #(
    parameter int REG_AW     = 5,
    parameter int NUM_SRC    = 2,
    parameter int FWD_STAGES = 2,
    parameter int LOAD_LAT   = 1,
    parameter int CNT_W      = 16,
    localparam int SELW      = $clog2(FWD_STAGES + 1)
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    input  logic [NUM_SRC*REG_AW-1:0]     i_src_ex_addr,
    input  logic [NUM_SRC-1:0]            i_src_ex_used,
    input  logic [NUM_SRC*REG_AW-1:0]     i_src_rr_addr,
    input  logic [NUM_SRC-1:0]            i_src_rr_used,
    input  logic [FWD_STAGES*REG_AW-1:0]  i_dst_addr,
    input  logic [FWD_STAGES-1:0]         i_dst_we,
    input  logic [REG_AW-1:0]             i_ex_rd,
    input  logic                          i_ex_we,
    input  logic                          i_ex_is_load,
    input  logic                          i_flush,
    input  logic                          i_cnt_clr,
    output logic [NUM_SRC*SELW-1:0]       o_fwd_sel,
    output logic [NUM_SRC-1:0]            o_rr_bypass,
    output logic                          o_stall,
    output logic                          o_bubble_ex,
    output logic [CNT_W-1:0]              o_stall_cnt
);

    localparam int REMW = $clog2(LOAD_LAT + 1);
    localparam int WB   = FWD_STAGES - 1;

    typedef enum logic {S_IDLE = 1'b0, S_STALL = 1'b1} state_t;

    state_t            r_state, w_state_nxt;
    logic [REMW-1:0]   r_rem, w_rem_nxt;
    logic [CNT_W-1:0]  r_cnt;
    logic [NUM_SRC*SELW-1:0] w_fwd_sel;
    logic [NUM_SRC-1:0]      w_rr_bypass;
    logic              w_hit;
    logic              w_stall;

    // EX operand forwarding. Stages are scanned oldest to youngest so the
    // youngest matching producer is the last assignment and wins.
    always_comb begin
        w_fwd_sel = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (i_src_ex_used[i] && (i_src_ex_addr[i*REG_AW +: REG_AW] != '0)) begin
                for (int k = FWD_STAGES; k >= 1; k--) begin
                    if (i_dst_we[k-1] &&
                        (i_dst_addr[(k-1)*REG_AW +: REG_AW] == i_src_ex_addr[i*REG_AW +: REG_AW])) begin
                        w_fwd_sel[i*SELW +: SELW] = SELW'(k);
                    end
                end
            end
        end
    end

    // WB write-through into RR, and load-use detection against the RR operands.
    always_comb begin
        w_rr_bypass = '0;
        w_hit       = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            w_rr_bypass[i] = i_src_rr_used[i] &&
                             (i_src_rr_addr[i*REG_AW +: REG_AW] != '0) &&
                             i_dst_we[WB] &&
                             (i_dst_addr[WB*REG_AW +: REG_AW] == i_src_rr_addr[i*REG_AW +: REG_AW]);
            if (i_src_rr_used[i] && (i_src_rr_addr[i*REG_AW +: REG_AW] == i_ex_rd)) begin
                w_hit = 1'b1;
            end
        end
        w_hit = w_hit && i_ex_we && i_ex_is_load && (i_ex_rd != '0);
    end

    // Stall FSM. The detection cycle is the first stall cycle (Mealy), so
    // STALL only covers the remaining LOAD_LAT-1 cycles. Hazards are not
    // re-evaluated in STALL: the bubble already sits in EX.
    always_comb begin
        w_state_nxt = r_state;
        w_rem_nxt   = r_rem;
        w_stall     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_hit && !i_flush) begin
                    w_stall = 1'b1;
                    if (LOAD_LAT > 1) begin
                        w_state_nxt = S_STALL;
                        w_rem_nxt   = REMW'(LOAD_LAT - 1);
                    end
                end
            end
            S_STALL: begin
                if (i_flush) begin
                    w_state_nxt = S_IDLE;
                    w_rem_nxt   = '0;
                end else begin
                    w_stall   = 1'b1;
                    w_rem_nxt = r_rem - REMW'(1);
                    if (r_rem == REMW'(1)) begin
                        w_state_nxt = S_IDLE;
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_rem_nxt   = '0;
            end
        endcase
        if (i_rst) begin
            w_stall = 1'b0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_IDLE;
            r_rem   <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_rem   <= w_rem_nxt;
            if (i_cnt_clr) begin
                r_cnt <= '0;
            end else if (w_stall && (r_cnt != '1)) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    assign o_fwd_sel   = i_rst ? '0 : w_fwd_sel;
    assign o_rr_bypass = i_rst ? '0 : w_rr_bypass;
    assign o_stall     = w_stall;
    assign o_bubble_ex = w_stall;
    assign o_stall_cnt = i_rst ? '0 : r_cnt;

endmodule
